idli_sqi_ctrl_m: RTL and testbench

- Sequences the external SQI SRAM for the idli core: drives SCK, CS, the 4-bit SIO bus and the IO direction.
- Arbitrates between two 16-bit word requesters: req 0 is instruction fetch, req 1 is data load/store.
- Converts each granted request into a complete SQI read (0x03) or write (0x02) transaction.
- Sits between the core's fetch/LSU logic and the top-level uio pins.

---
 rtl/idli_sqi_ctrl_m.sv | 168 ++++++++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM sequencer for the idli core: arbitrates fetch/LSU word requests into 0x03/0x02 transactions.
// Optional: define IDLI_SQI_FETCH_PRIO_EN for fixed fetch priority instead of round-robin.
module idli_sqi_ctrl_m #(
  parameter int unsigned GAP_CYC = 2,
  parameter logic [7:0]  ADDR_HI = 8'h00
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic [1:0]  i_sqi_req,
  input  logic [1:0]  i_sqi_we,
  input  logic [15:0] i_sqi_addr0,
  input  logic [15:0] i_sqi_addr1,
  input  logic [15:0] i_sqi_wdata0,
  input  logic [15:0] i_sqi_wdata1,
  output logic [1:0]  o_sqi_gnt,
  output logic [15:0] o_sqi_rdata,
  output logic [1:0]  o_sqi_rvld,
  output logic [1:0]  o_sqi_wdone,
  output logic        o_sqi_sck,
  output logic        o_sqi_cs,
  output logic        o_sqi_io_mode,
  output logic [3:0]  o_sqi_sio,
  input  logic [3:0]  i_sqi_sio
);
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_GAP} state_t;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t           state_q, nxt_st;
  logic             sck_q, cs_q, io_q;
  logic [3:0]       sio_q;
  logic [1:0]       gnt_q, rvld_q, wdone_q, own_q;
  logic [15:0]      rdata_q;
  logic [2:0]       nib_q;
  logic [GAP_W-1:0] gap_q;
  logic             we_q;
  logic [47:0]      sh_q;
  logic [11:0]      rd_q;
  logic             nib_last, gap_last, arb_ok, sel_we;
  logic [1:0]       sel;
  logic [15:0]      sel_addr, sel_wdata;
`ifndef IDLI_SQI_FETCH_PRIO_EN
  logic             rr_q;
`endif

  always_comb begin
    nib_last = 1'b0;
    nxt_st   = state_q;
    case (state_q)
      ST_CMD:   begin nib_last = (nib_q == 3'd1); nxt_st = ST_ADDR; end
      ST_ADDR:  begin nib_last = (nib_q == 3'd5); nxt_st = we_q ? ST_DATA : ST_DUMMY; end
      ST_DUMMY: begin nib_last = (nib_q == 3'd1); nxt_st = ST_DATA; end
      ST_DATA:  begin nib_last = (nib_q == 3'd3); nxt_st = ST_GAP; end
      default:  ;
    endcase
    gap_last = (state_q == ST_GAP) && (gap_q == GAP_W'(GAP_CYC - 1));
    // Arbitration also runs on the last GAP cycle so a waiting request's gnt lands in the first IDLE cycle.
    arb_ok   = ((state_q == ST_IDLE) && (gnt_q == '0)) || gap_last;
`ifdef IDLI_SQI_FETCH_PRIO_EN
    sel[0]   = i_sqi_req[0];
`else
    sel[0]   = i_sqi_req[0] & (~i_sqi_req[1] | ~rr_q);
`endif
    sel[1]    = i_sqi_req[1] & ~sel[0];
    sel_we    = sel[1] ? i_sqi_we[1]    : i_sqi_we[0];
    sel_addr  = sel[1] ? i_sqi_addr1    : i_sqi_addr0;
    sel_wdata = sel[1] ? i_sqi_wdata1   : i_sqi_wdata0;
  end

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state_q <= ST_IDLE;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      io_q    <= 1'b0;
      sio_q   <= '0;
      gnt_q   <= '0;
      rvld_q  <= '0;
      wdone_q <= '0;
      rdata_q <= '0;
      nib_q   <= '0;
      gap_q   <= '0;
      we_q    <= 1'b0;
      own_q   <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
`ifndef IDLI_SQI_FETCH_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      gnt_q   <= '0;
      rvld_q  <= '0;
      wdone_q <= '0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_q != '0) begin
            state_q <= ST_CMD;
            cs_q    <= 1'b0;
            io_q    <= 1'b1;
            sio_q   <= sh_q[47:44];
            sh_q    <= {sh_q[43:0], 4'h0};
            nib_q   <= '0;
          end
        end
        ST_GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_last) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
          end
        end
        default: begin
          if (!sck_q) begin
            sck_q <= 1'b1;
          end else begin
            sck_q <= 1'b0;
            if (state_q == ST_DATA && !we_q) rd_q <= {rd_q[7:0], i_sqi_sio};
            if (!nib_last) begin
              nib_q <= nib_q + 3'd1;
              if (io_q) begin
                sio_q <= sh_q[47:44];
                sh_q  <= {sh_q[43:0], 4'h0};
              end
            end else begin
              nib_q   <= '0;
              state_q <= nxt_st;
              if (nxt_st == ST_GAP) begin
                cs_q  <= 1'b1;
                io_q  <= 1'b0;
                sio_q <= '0;
                if (we_q) begin
                  wdone_q <= own_q;
                end else begin
                  rvld_q  <= own_q;
                  rdata_q <= {rd_q, i_sqi_sio};
                end
              end else if (nxt_st == ST_DUMMY) begin
                io_q  <= 1'b0;
                sio_q <= '0;
              end else if (io_q) begin
                sio_q <= sh_q[47:44];
                sh_q  <= {sh_q[43:0], 4'h0};
              end
            end
          end
        end
      endcase
      if (arb_ok && sel != '0) begin
        gnt_q <= sel;
        own_q <= sel;
        we_q  <= sel_we;
        sh_q  <= {4'h0, (sel_we ? 4'h2 : 4'h3), ADDR_HI, sel_addr, sel_wdata};
`ifndef IDLI_SQI_FETCH_PRIO_EN
        rr_q  <= sel[0];
`endif
      end
    end
  end

  assign o_sqi_gnt     = gnt_q;
  assign o_sqi_rdata   = rdata_q;
  assign o_sqi_rvld    = rvld_q;
  assign o_sqi_wdone   = wdone_q;
  assign o_sqi_sck     = sck_q;
  assign o_sqi_cs      = cs_q;
  assign o_sqi_io_mode = io_q;
  assign o_sqi_sio     = sio_q;
endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m with a small SQI SRAM model.
module tb_idli_sqi_ctrl_m;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [15:0] a0, a1, w0, w1;
  logic [1:0]  gnt, rvld, wdone;
  logic [15:0] rdata;
  logic        sck, cs, iom;
  logic [3:0]  sio_o, sio_i;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  idli_sqi_ctrl_m #(.GAP_CYC(2), .ADDR_HI(8'h00)) dut (
    .i_sqi_gck(clk), .i_sqi_rst(rst), .i_sqi_req(req), .i_sqi_we(we),
    .i_sqi_addr0(a0), .i_sqi_addr1(a1), .i_sqi_wdata0(w0), .i_sqi_wdata1(w1),
    .o_sqi_gnt(gnt), .o_sqi_rdata(rdata), .o_sqi_rvld(rvld), .o_sqi_wdone(wdone),
    .o_sqi_sck(sck), .o_sqi_cs(cs), .o_sqi_io_mode(iom), .o_sqi_sio(sio_o),
    .i_sqi_sio(sio_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model: samples on sck rise, drives read nibbles during the controller's phase B
  logic [15:0] mem [logic [15:0]];
  logic [63:0] outsh;
  int          ncnt;
  logic [3:0]  m_cmd;
  logic [15:0] m_addr, rword, rsh;

  always @(posedge sck or negedge cs) begin
    if (!sck) begin
      ncnt  = 0;
      outsh = '0;
    end else if (!cs) begin
      outsh = {outsh[59:0], sio_o};
      ncnt++;
      if (ncnt == 8) begin
        m_cmd  = outsh[27:24];
        m_addr = outsh[15:0];
        rword  = mem.exists(m_addr) ? mem[m_addr] : 16'h0000;
      end
      if (m_cmd == 4'h3 && ncnt >= 11 && ncnt <= 14) begin
        rsh   = rword >> (4 * (14 - ncnt));
        sio_i = rsh[3:0];
      end
      if (m_cmd == 4'h2 && ncnt == 12) mem[m_addr] = outsh[15:0];
    end
  end

  logic [1:0]  t_gnt, t_rv, t_wd, t_sck;
  int          t_csf, t_done, t_iohi, t_iolo, t_rdnz, t_gx, t_csl;
  logic [15:0] t_rd;
  logic        t_csd;

  task automatic xact(input logic [1:0] r, input logic [1:0] w, input int rst_at,
                      input int p_on, input int p_off);
    logic isw;
    isw    = |(r & w);
    t_gnt  = '0; t_rv = '0; t_wd = '0; t_sck = '0; t_rd = '0; t_csd = 1'b0;
    t_csf  = -1; t_done = -1; t_iohi = 0; t_iolo = 0; t_rdnz = 0; t_gx = 0; t_csl = 0;
    req = r;
    we  = w;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 0) begin
        t_gnt = gnt;
        req   = '0;
      end else if (gnt != '0) t_gx++;
      if (!cs && t_csf < 0) t_csf = k;
      if (k == 1) t_sck[1] = sck;
      if (k == 2) t_sck[0] = sck;
      if (rvld != '0 || wdone != '0) begin
        if (t_done < 0) begin
          t_done = k; t_rv = rvld; t_wd = wdone; t_rd = rdata; t_csd = cs;
        end
      end else if (rdata != '0) t_rdnz++;
      if (k >= 1 && k <= (isw ? 24 : 16) && iom) t_iohi++;
      if (!isw && k >= 17 && k <= 28 && (iom || sio_o != '0)) t_iolo++;
      if (t_done >= 0 && k > t_done && !cs) t_csl++;
      if (k == p_on)  req[1] = 1'b1;
      if (k == p_off) req[1] = 1'b0;
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_cs_async", cs, 1);
        chk("rst_io_async", iom, 0);
        @(negedge clk);
        rst = 1'b0;
      end
    end
  endtask

  logic [1:0] gl [4];
  logic [1:0] gexp [4];
  int ng, both, mingap, run;
  logic seenlow;

  initial begin
    rst = 1'b1; req = '0; we = '0; a0 = '0; a1 = '0; w0 = '0; w1 = '0; sio_i = '0;
    mem[16'h1234] = 16'hBEEF;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvld", rvld, 0);
    chk("rst_wdone", wdone, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_sck", sck, 0);
    chk("rst_cs", cs, 1);
    chk("rst_iomode", iom, 0);
    chk("rst_sio", sio_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // single read on requester 0
    a0 = 16'h1234;
    xact(2'b01, 2'b00, -1, -1, -1);
    chk("rd_gnt", t_gnt, 2'b01);
    chk("rd_cs_fall", t_csf, 1);
    chk("rd_sck_ab", t_sck, 2'b01);
    chk("rd_done_cyc", t_done, 29);
    chk("rd_rvld", t_rv, 2'b01);
    chk("rd_wdone", t_wd, 2'b00);
    chk("rd_rdata", t_rd, 16'hBEEF);
    chk("rd_cs_rise", t_csd, 1);
    chk("rd_io_cmdaddr", t_iohi, 16);
    chk("rd_io_turn", t_iolo, 0);
    chk("rd_rdata_clr", t_rdnz, 0);
    chk("rd_xgnt", t_gx, 0);
    chk("rd_cs_after", t_csl, 0);
    chk("rd_nibs", outsh[55:0], 56'h03001234000000);
    chk("rd_ncnt", ncnt, 14);

    // single write on requester 1
    a1 = 16'h00F0; w1 = 16'hA5C3;
    xact(2'b10, 2'b10, -1, -1, -1);
    chk("wr_gnt", t_gnt, 2'b10);
    chk("wr_cs_fall", t_csf, 1);
    chk("wr_done_cyc", t_done, 25);
    chk("wr_wdone", t_wd, 2'b10);
    chk("wr_rvld", t_rv, 2'b00);
    chk("wr_cs_rise", t_csd, 1);
    chk("wr_io", t_iohi, 24);
    chk("wr_nibs", outsh[47:0], 48'h020000F0A5C3);
    chk("wr_ncnt", ncnt, 12);
    chk("wr_mem", mem[16'h00F0], 16'hA5C3);

    // contention: both held for four grants
    a0 = 16'h1234; a1 = 16'h1234;
`ifdef IDLI_SQI_FETCH_PRIO_EN
    gexp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    gl = '{2'b00, 2'b00, 2'b00, 2'b00};
    req = 2'b11; we = '0; ng = 0; both = 0; mingap = 1000; run = 0; seenlow = 1'b0;
    for (int k = 0; k < 400 && ng < 4; k++) begin
      @(negedge clk);
      if (gnt == 2'b11) both++;
      if (gnt != '0) begin
        gl[ng] = gnt;
        ng++;
        if (ng == 4) req = '0;
      end
      if (cs) run++;
      else begin
        if (seenlow && run > 0 && run < mingap) mingap = run;
        seenlow = 1'b1;
        run = 0;
      end
    end
    req = '0;
    repeat (40) @(negedge clk);
    chk("cont_ngnt", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_gnt%0d", i), gl[i], gexp[i]);
    chk("cont_onehot", both, 0);
    chk("cont_gap", (mingap >= 2 && mingap < 1000), 1);

    // reset during ADDR nibble 3, then a clean read
    xact(2'b01, 2'b00, 11, -1, -1);
    chk("rstm_cs_fall", t_csf, 1);
    chk("rstm_no_done", t_done, -1);
    xact(2'b01, 2'b00, -1, -1, -1);
    chk("rstm_gnt", t_gnt, 2'b01);
    chk("rstm_done_cyc", t_done, 29);
    chk("rstm_rdata", t_rd, 16'hBEEF);

    // write on requester 0 with req[1] raised and dropped inside GAP
    a0 = 16'h0010; w0 = 16'h1357;
    xact(2'b01, 2'b01, -1, 25, 26);
    chk("wd_done_cyc", t_done, 25);
    chk("wd_wdone", t_wd, 2'b01);
    chk("wd_nibs", outsh[47:0], 48'h020000101357);
    chk("wd_mem", mem[16'h0010], 16'h1357);
    chk("wd_no_gnt", t_gx, 0);
    chk("wd_cs_high", t_csl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
